// File: rtl/pipeline_sequencer_if.sv
// Debug-command inputs, hazard/redirect inputs and the sequencer's
// control, status and counter outputs, bundled between the debug unit,
// the hazard unit and the datapath.
//
// Handshake: there is no valid/ready pair here. o_valid is a one-way
// advance strobe. Every stage consumes it in the same cycle and it can
// never be back-pressured; the only brake is i_hazard, which keeps
// o_valid high but turns the cycle into a stall (PC/IF-ID hold, ID/EX
// bubble).
interface pipeline_sequencer_if #(
    parameter int NB_COUNT = 32
);
    logic                i_run;
    logic                i_step;
    logic                i_hazard;
    logic                i_branch_taken;
    logic                i_halt;
    logic                o_valid;
    logic                o_pc_we;
    logic                o_ifid_we;
    logic                o_ifid_flush;
    logic                o_idex_bubble;
    logic                o_halted;
    logic                o_error;
    logic [1:0]          o_state;
    logic [NB_COUNT-1:0] o_cycle_count;
    logic [NB_COUNT-1:0] o_stall_count;

    // Sequencer side
    modport slave (
        input  i_run, i_step, i_hazard, i_branch_taken, i_halt,
        output o_valid, o_pc_we, o_ifid_we, o_ifid_flush, o_idex_bubble,
               o_halted, o_error, o_state, o_cycle_count, o_stall_count
    );

    // Debug unit / datapath side
    modport master (
        output i_run, i_step, i_hazard, i_branch_taken, i_halt,
        input  o_valid, o_pc_we, o_ifid_we, o_ifid_flush, o_idex_bubble,
               o_halted, o_error, o_state, o_cycle_count, o_stall_count
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// Run/step/stall sequencer for the 5-stage pipeline. It produces the
// global advance strobe and turns hazard stalls and branch redirects into
// per-register write enables, flush and bubble. It also keeps cycle/stall
// counters and a watchdog on consecutive stalls.
module pipeline_sequencer #(
    parameter int NB_COUNT  = 32,
    parameter int MAX_STALL = 4,
    parameter int NB_STALL  = 3
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    pipeline_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10,
        ST_HALTED = 2'b11
    } state_e;

    localparam logic [NB_STALL-1:0] TRIP_AT = NB_STALL'(MAX_STALL - 1);

    state_e              state_q, state_d;
    logic                step_prev_q;
    logic [NB_STALL-1:0] consec_q, consec_d;
    logic                error_q, error_d;
    logic [NB_COUNT-1:0] cycle_q, cycle_d;
    logic [NB_COUNT-1:0] stall_q, stall_d;

    logic valid;
    logic step_pulse;
    logic trip;

    assign valid      = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign step_pulse = bus.i_step & ~step_prev_q;
    assign trip       = valid & bus.i_hazard & (consec_q == TRIP_AT);

    // State, step edge detector, watchdog and counters
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_IDLE;
            step_prev_q <= 1'b1;  // a step held through reset must not fire
            consec_q    <= '0;
            error_q     <= 1'b0;
            cycle_q     <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            step_prev_q <= bus.i_step;
            consec_q    <= consec_d;
            error_q     <= error_d;
            cycle_q     <= cycle_d;
            stall_q     <= stall_d;
        end
    end

    // Next-state: halt/watchdog on an advance cycle beats the per-state rules
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_run)       state_d = ST_RUN;
                else if (step_pulse) state_d = ST_STEP;
            end
            ST_RUN:  if (!bus.i_run) state_d = ST_IDLE;
            ST_STEP: state_d = ST_IDLE;
            default: state_d = ST_HALTED;
        endcase
        if (state_q != ST_HALTED && valid && (bus.i_halt || trip))
            state_d = ST_HALTED;
    end

    // Watchdog and saturating counters only move on advance cycles
    always_comb begin
        consec_d = consec_q;
        error_d  = error_q | trip;
        cycle_d  = cycle_q;
        stall_d  = stall_q;
        if (valid) begin
            consec_d = bus.i_hazard ? consec_q + 1'b1 : '0;
            if (cycle_q != '1) cycle_d = cycle_q + 1'b1;
            if (bus.i_hazard && stall_q != '1) stall_d = stall_q + 1'b1;
        end
    end

    // Datapath controls: a stall beats a redirect; the branch is resolved again next cycle
    always_comb begin
        bus.o_pc_we       = 1'b0;
        bus.o_ifid_we     = 1'b0;
        bus.o_ifid_flush  = 1'b0;
        bus.o_idex_bubble = 1'b0;
        if (valid) begin
            if (bus.i_hazard) begin
                bus.o_idex_bubble = 1'b1;
            end else begin
                bus.o_pc_we      = 1'b1;
                bus.o_ifid_we    = 1'b1;
                bus.o_ifid_flush = bus.i_branch_taken;
            end
        end
    end

    assign bus.o_valid       = valid;
    assign bus.o_halted      = (state_q == ST_HALTED);
    assign bus.o_error       = error_q;
    assign bus.o_state       = state_q;
    assign bus.o_cycle_count = cycle_q;
    assign bus.o_stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: a control-decode vector table
// plus hand-written sequences for step edges, run/step collision,
// watchdog trip, halt and asynchronous reset.
module tb_pipeline_sequencer;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    pipeline_sequencer_if #(.NB_COUNT(32)) bus();

    pipeline_sequencer #(
        .NB_COUNT (32),
        .MAX_STALL(4),
        .NB_STALL (3)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .bus    (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       adv;      // 1: applied in RUN, 0: applied in IDLE
        logic       hazard;
        logic       branch;
        logic [3:0] exp_ctl;  // {pc_we, ifid_we, ifid_flush, idex_bubble}
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic run, input logic step, input logic hz,
                          input logic br, input logic halt);
        bus.i_run          = run;
        bus.i_step         = step;
        bus.i_hazard       = hz;
        bus.i_branch_taken = br;
        bus.i_halt         = halt;
    endtask

    task automatic do_reset(input logic step_lvl);
        set_in(1'b0, step_lvl, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] ctl();
        return {bus.o_pc_we, bus.o_ifid_we, bus.o_ifid_flush, bus.o_idex_bubble};
    endfunction

    initial begin
        int exp_cycle;
        int exp_stall;
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'b1100});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'b0001});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 4'b1110});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 4'b0001});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 4'b1110});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'b0001});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 4'b0001});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'b0001});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'b1100});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'b0000});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'b0000});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'b0000});

        // Reset values, step held high through reset release
        do_reset(1'b1);
        check("rst_state", 32'(bus.o_state), 32'd0);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_ctl", 32'(ctl()), 32'd0);
        check("rst_halted", 32'(bus.o_halted), 32'd0);
        check("rst_error", 32'(bus.o_error), 32'd0);
        repeat (3) tick();
        check("step_held_state", 32'(bus.o_state), 32'd0);
        check("step_held_cycles", bus.o_cycle_count, 32'd0);
        bus.i_step = 1'b0;
        tick();
        bus.i_step = 1'b1;
        tick();
        check("step_state", 32'(bus.o_state), 32'd2);
        check("step_valid", 32'(bus.o_valid), 32'd1);
        check("step_ctl", 32'(ctl()), 32'hC);
        tick();
        check("step_back_idle", 32'(bus.o_state), 32'd0);
        check("step_valid_off", 32'(bus.o_valid), 32'd0);
        check("step_cycles", bus.o_cycle_count, 32'd1);
        repeat (2) tick();
        check("step_no_refire", 32'(bus.o_state), 32'd0);
        check("step_cycles_hold", bus.o_cycle_count, 32'd1);

        // Control decode table: advance vectors in RUN, then idle vectors
        do_reset(1'b0);
        exp_cycle = 0;
        exp_stall = 0;
        bus.i_run = 1'b1;
        tick();
        foreach (vecs[i]) begin
            if (!vecs[i].adv && bus.o_state == 2'd1) begin
                set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                tick();
                exp_cycle++;
            end
            bus.i_hazard       = vecs[i].hazard;
            bus.i_branch_taken = vecs[i].branch;
            #1;
            check($sformatf("vec%0d_valid", i), 32'(bus.o_valid), 32'(vecs[i].adv));
            check($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(vecs[i].exp_ctl));
            tick();
            if (vecs[i].adv) begin
                exp_cycle++;
                if (vecs[i].hazard) exp_stall++;
            end
        end
        check("tbl_cycles", bus.o_cycle_count, 32'(exp_cycle));
        check("tbl_stalls", bus.o_stall_count, 32'(exp_stall));
        check("tbl_error", 32'(bus.o_error), 32'd0);

        // RUN 10 advance cycles with a stall in cycle 4
        do_reset(1'b0);
        bus.i_run = 1'b1;
        tick();
        for (int c = 1; c <= 10; c++) begin
            bus.i_hazard = (c == 4);
            bus.i_run    = (c < 10);
            #1;
            if (c == 4) check("run10_stall_ctl", 32'(ctl()), 32'h1);
            if (c == 5) check("run10_after_ctl", 32'(ctl()), 32'hC);
            tick();
        end
        bus.i_hazard = 1'b0;
        check("run10_idle", 32'(bus.o_state), 32'd0);
        check("run10_cycles", bus.o_cycle_count, 32'd10);
        check("run10_stalls", bus.o_stall_count, 32'd1);

        // Watchdog: hazard held high trips on the 4th stalled cycle
        do_reset(1'b0);
        bus.i_run = 1'b1;
        tick();
        bus.i_hazard = 1'b1;
        repeat (3) tick();
        check("wd_pre_state", 32'(bus.o_state), 32'd1);
        check("wd_pre_error", 32'(bus.o_error), 32'd0);
        tick();
        check("wd_state", 32'(bus.o_state), 32'd3);
        check("wd_error", 32'(bus.o_error), 32'd1);
        check("wd_halted", 32'(bus.o_halted), 32'd1);
        check("wd_valid", 32'(bus.o_valid), 32'd0);
        check("wd_stalls", bus.o_stall_count, 32'd4);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        bus.i_run = 1'b1;
        repeat (2) tick();
        check("wd_sticky_state", 32'(bus.o_state), 32'd3);
        check("wd_sticky_cycles", bus.o_cycle_count, 32'd4);
        check("wd_sticky_error", 32'(bus.o_error), 32'd1);

        // HALT in WB at advance cycle 7
        do_reset(1'b0);
        bus.i_run = 1'b1;
        tick();
        for (int c = 1; c <= 7; c++) begin
            bus.i_halt = (c == 7);
            tick();
        end
        bus.i_halt = 1'b0;
        check("halt_state", 32'(bus.o_state), 32'd3);
        check("halt_halted", 32'(bus.o_halted), 32'd1);
        check("halt_valid", 32'(bus.o_valid), 32'd0);
        check("halt_error", 32'(bus.o_error), 32'd0);
        check("halt_cycles", bus.o_cycle_count, 32'd7);
        tick();
        check("halt_cycles_hold", bus.o_cycle_count, 32'd7);

        // Run and step edge in the same cycle: RUN wins, step discarded
        do_reset(1'b0);
        tick();
        bus.i_run  = 1'b1;
        bus.i_step = 1'b1;
        tick();
        check("rs_state", 32'(bus.o_state), 32'd1);
        repeat (2) tick();
        bus.i_run = 1'b0;
        #1;
        check("rs_trailing_valid", 32'(bus.o_valid), 32'd1);
        tick();
        check("rs_idle", 32'(bus.o_state), 32'd0);
        check("rs_cycles", bus.o_cycle_count, 32'd3);
        tick();
        check("rs_no_step", 32'(bus.o_state), 32'd0);
        check("rs_cycles_hold", bus.o_cycle_count, 32'd3);

        // Asynchronous reset mid-RUN aborts immediately
        bus.i_run = 1'b1;
        repeat (2) tick();
        check("ar_pre_valid", 32'(bus.o_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("ar_state", 32'(bus.o_state), 32'd0);
        check("ar_valid", 32'(bus.o_valid), 32'd0);
        check("ar_ctl", 32'(ctl()), 32'd0);
        check("ar_cycles", bus.o_cycle_count, 32'd0);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Top-level run/step/stall sequencer for the 5-stage MIPS pipeline. Generates the global advance strobe (`o_valid`) that feeds every stage's `i_valid`, and converts the hazard unit's stall request and the ID-stage branch/jump redirect into per-register write-enables, flush and bubble controls. Sits between the debug unit (run/step commands) and the datapath, and also provides cycle/stall counters plus a stall watchdog.

## Interface
Parameters:
- `NB_COUNT`, 32, width of cycle and stall counters.
- `MAX_STALL`, 4, consecutive stalled advance cycles that trip the watchdog (≥1).
- `NB_STALL`, 3, width of the consecutive-stall counter; must hold `MAX_STALL`.

Ports:
- `i_clock`  in  1  pipeline clock; all state updates on rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_run`  in  1  debug continuous-run level.
- `i_step`  in  1  debug single-step request; acts on rising edge.
- `i_hazard`  in  1  stall request from hazard unit (`o_hazard`).
- `i_branch_taken`  in  1  ID resolved a taken branch or jump this cycle.
- `i_halt`  in  1  HALT instruction present in WB.
- `o_valid`  out  1  global pipeline advance strobe.
- `o_pc_we`  out  1  PC register write enable.
- `o_ifid_we`  out  1  IF/ID register write enable.
- `o_ifid_flush`  out  1  IF/ID loads a NOP.
- `o_idex_bubble`  out  1  ID/EX loads a NOP (control bits zeroed).
- `o_halted`  out  1  program finished or watchdog tripped.
- `o_error`  out  1  sticky watchdog flag.
- `o_state`  out  2  current FSM state encoding.
- `o_cycle_count`  out  `NB_COUNT`  advance cycles since reset.
- `o_stall_count`  out  `NB_COUNT`  advance cycles with `i_hazard`=1.

## Operation
- FSM states: IDLE=2'b00, RUN=2'b01, STEP=2'b10, HALTED=2'b11. `o_state` = state register.
- Step edge: `step_d` register samples `i_step` each clock; `step_pulse = i_step & ~step_d`. `step_d` resets to 1, so a step held through reset does not fire.
- Transitions (priority top-down):
  - Any state ≠ HALTED, advancing, and (`i_halt` or watchdog trip) → HALTED.
  - IDLE: `i_run`=1 → RUN; else `step_pulse` → STEP; else stay. `i_run` and `step_pulse` together: RUN, step discarded.
  - RUN: `i_run`=0 → IDLE; else stay.
  - STEP: → IDLE unconditionally (exactly one advance cycle).
  - HALTED: terminal; leaves only by reset.
- `o_valid` = 1 in RUN or STEP, else 0 (Moore decode).
- Controls when `o_valid`=0: `o_pc_we`=`o_ifid_we`=`o_ifid_flush`=`o_idex_bubble`=0.
- Controls when `o_valid`=1 (combinational, stall beats redirect):
  - `i_hazard`=1: `o_pc_we`=0, `o_ifid_we`=0, `o_idex_bubble`=1, `o_ifid_flush`=0 (branch re-evaluated next cycle).
  - else `i_branch_taken`=1: `o_pc_we`=1, `o_ifid_we`=1, `o_ifid_flush`=1, `o_idex_bubble`=0.
  - else: `o_pc_we`=1, `o_ifid_we`=1, flush/bubble 0.
- Counters: on each clock with `o_valid`=1, `o_cycle_count`+1; if also `i_hazard`, `o_stall_count`+1. Both saturate at all-ones (no wrap).
- Watchdog: `consec` increments on advance cycles with `i_hazard`, clears on advance cycles without; holds when `o_valid`=0. Trip when `consec` == `MAX_STALL`-1 and `i_hazard`=1 on an advance cycle: `o_error`←1 (sticky), state → HALTED.
- `o_halted` = (state == HALTED).

## Timing
- Reset (async, `i_reset`=0): state IDLE, `step_d`=1, `consec`=0, counters 0, `o_error`=0; hence `o_valid`, all enables, flush, bubble, `o_halted` = 0 immediately.
- `i_run` sampled high at edge N → `o_valid`=1 from N until the edge after `i_run` is sampled low (one trailing advance cycle).
- `step_pulse` at edge N → `o_valid`=1 for cycle N..N+1 only.
- `i_halt` sampled on advance at edge N: that cycle counts; `o_valid`=0 after N.
- Control outputs have zero latency from `i_hazard`/`i_branch_taken` within an advance cycle.
- Reset mid-RUN or mid-STEP aborts immediately; no drain.

## Test plan
- Reset, `i_step` held high through release → stays IDLE, `o_cycle_count`=0; toggle `i_step` low/high → exactly one `o_valid` cycle, count=1, back to IDLE.
- RUN 10 cycles, `i_hazard` high in cycle 4 → `o_pc_we`=`o_ifid_we`=0, `o_idex_bubble`=1 that cycle; cycle_count=10, stall_count=1.
- RUN with `i_hazard`=1 and `i_branch_taken`=1 same cycle → bubble=1, flush=0; next cycle hazard=0, branch=1 → flush=1, pc_we=1.
- RUN, `i_hazard` held high, `MAX_STALL`=4 → after 4th stalled cycle `o_error`=1, `o_halted`=1, `o_valid`=0; `i_run` toggling has no effect until reset.
- RUN, `i_halt` pulse at cycle 7 → HALTED, cycle_count=7, `o_error`=0.
- IDLE with `i_run` rising and step edge same cycle → RUN, no extra STEP afterwards; drop `i_run` → one trailing advance then IDLE.
